id_stage_pipe: RTL and testbench
================================

ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

Interface
REQ-001 The block SHALL have these parameters: NB_DATA, 32, register/operand width (>=32); NB_REG_ADDR, 5, register index width (2^NB_REG_ADDR registers); NB_CNT, 8, stall-counter width.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset: clk input 1 rising-edge clock; i_rst input 1 asynchronous active-high reset.
REQ-003 The block SHALL have these upstream ports: i_valid input 1 instruction valid; i_instruction input 32 MIPS word; i_pc4 input NB_DATA PC+4; o_ready output 1 stage can accept.
REQ-004 The block SHALL have these hazard and flush ports: i_ex_mem_read input 1 load in EX; i_ex_rt input NB_REG_ADDR load destination; i_flush input 1 branch/jump taken; i_ready input 1 EX can accept.
REQ-005 The block SHALL have these writeback ports: i_wb_we input 1; i_wb_addr input NB_REG_ADDR; i_wb_data input NB_DATA.
REQ-006 The block SHALL have these data outputs, all registered: o_valid 1; o_opcode 6; o_func 6; o_shamt 5; o_rs, o_rt, o_rd NB_REG_ADDR; o_data_a, o_data_b NB_DATA; o_imm NB_DATA; o_jaddr 26; o_pc4 NB_DATA.
REQ-007 The block SHALL have these control outputs, all registered: o_reg_write, o_mem_read, o_mem_write, o_mem2reg, o_reg_dst, o_alu_src, o_branch, o_jump, each 1; o_stall_cnt NB_CNT saturating load-use stall count.

Function
REQ-008 Register file SHALL hold 2^NB_REG_ADDR x NB_DATA entries; register 0 SHALL read 0 and ignore writes.
REQ-009 A write SHALL occur at the rising clk edge when i_wb_we=1 and i_wb_addr!=0.
REQ-010 Reads of rs=i_instruction[25:21] and rt=[20:16] SHALL be combinational with write-through: same-cycle write to the read address returns i_wb_data.
REQ-011 Hazard SHALL be i_valid & i_ex_mem_read & i_ex_rt!=0 & (i_ex_rt==rs | i_ex_rt==rt).
REQ-012 o_ready SHALL be i_ready & ~hazard, or 1 when i_flush=1.
REQ-013 Output register update priority per edge SHALL be: i_flush, then hold, then bubble, then load.
REQ-014 i_flush=1 SHALL load a bubble, overriding hold.
REQ-015 When i_ready=0 and i_flush=0 (hold), all outputs SHALL be held.
REQ-016 When a hazard occurs with i_ready=1 and no flush, a bubble SHALL be loaded and o_stall_cnt SHALL increment, saturating at 2^NB_CNT-1.
REQ-017 When i_valid=1 with i_ready=1, no hazard and no flush, decoded fields SHALL be loaded and o_valid=1.
REQ-018 When i_valid=0 with i_ready=1, no hazard and no flush, a bubble SHALL be loaded.
REQ-019 A bubble SHALL set o_valid and all control outputs to 0; data fields are don't-care but SHALL be driven 0.
REQ-020 Latency SHALL be 1 cycle: an instruction accepted at edge k SHALL be on the outputs after edge k.
REQ-021 Field extraction SHALL be opcode[31:26], rd[15:11], shamt[10:6], func[5:0], jaddr[25:0].
REQ-022 Immediate SHALL be zero-extended for andi 0x0C, ori 0x0D and xori 0x0E; lui 0x0F SHALL give imm<<16, zero-extended; all other opcodes SHALL sign-extend to NB_DATA.
REQ-023 Control SHALL decode as follows: R-type 0x00: reg_write, reg_dst.
REQ-024 addi 0x08, andi, ori, xori, lui, slti 0x0A: reg_write, alu_src.
REQ-025 lw 0x23: reg_write, alu_src, mem_read, mem2reg.
REQ-026 sw 0x2B: alu_src, mem_write.
REQ-027 beq 0x04 and bne 0x05: branch.
REQ-028 j 0x02: jump.
REQ-029 jal 0x03: jump, reg_write.
REQ-030 Any other opcode SHALL decode with all control 0 and o_valid=1.
REQ-031 R-type with func 0x08 (jr) SHALL assert jump and SHALL NOT assert reg_write.

Reset
REQ-032 While i_rst=1, all outputs including o_valid and o_stall_cnt SHALL be 0 and all registers SHALL be cleared to 0, asynchronously.
REQ-033 On deassertion, the first edge with i_rst=0 SHALL operate normally.
REQ-034 Reset mid-hold or mid-hazard SHALL discard the held state.

Verification
REQ-035 WB r5=0x1234 and read rs=5 in the same cycle -> o_data_a=0x1234 next cycle; write r0=0xFFFF -> reads 0.
REQ-036 lw in EX (i_ex_mem_read=1, i_ex_rt=8) with add rs=8 in ID -> o_ready=0, bubble out, o_stall_cnt=1; next cycle with no hazard -> add appears with o_valid=1.
REQ-037 i_ready=0 for 3 cycles with a valid instruction -> outputs constant, o_ready=0; i_flush during hold -> bubble, o_ready=1.
REQ-038 addi imm 0xFFF0 -> o_imm=0xFFFFFFF0; ori 0xFFF0 -> 0x0000FFF0; lui 0x1234 -> 0x12340000.
REQ-039 Drive 300 consecutive hazard cycles with NB_CNT=8 -> o_stall_cnt=255, no wrap.
REQ-040 Assert i_rst mid-stream -> all outputs 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/id_stage_pipe.sv
// MIPS instruction-decode stage: register file with write-through, load-use hazard
// detection, immediate/control decode and a one-deep output register with hold/flush.
module id_stage_pipe #(
    parameter int NB_DATA     = 32,
    parameter int NB_REG_ADDR = 5,
    parameter int NB_CNT      = 8
) (
    input  logic                   clk,
    input  logic                   i_rst,
    // upstream
    input  logic                   i_valid,
    input  logic [31:0]            i_instruction,
    input  logic [NB_DATA-1:0]     i_pc4,
    output logic                   o_ready,
    // hazard / flush
    input  logic                   i_ex_mem_read,
    input  logic [NB_REG_ADDR-1:0] i_ex_rt,
    input  logic                   i_flush,
    input  logic                   i_ready,
    // writeback
    input  logic                   i_wb_we,
    input  logic [NB_REG_ADDR-1:0] i_wb_addr,
    input  logic [NB_DATA-1:0]     i_wb_data,
    // decoded data
    output logic                   o_valid,
    output logic [5:0]             o_opcode,
    output logic [5:0]             o_func,
    output logic [4:0]             o_shamt,
    output logic [NB_REG_ADDR-1:0] o_rs,
    output logic [NB_REG_ADDR-1:0] o_rt,
    output logic [NB_REG_ADDR-1:0] o_rd,
    output logic [NB_DATA-1:0]     o_data_a,
    output logic [NB_DATA-1:0]     o_data_b,
    output logic [NB_DATA-1:0]     o_imm,
    output logic [25:0]            o_jaddr,
    output logic [NB_DATA-1:0]     o_pc4,
    // decoded control
    output logic                   o_reg_write,
    output logic                   o_mem_read,
    output logic                   o_mem_write,
    output logic                   o_mem2reg,
    output logic                   o_reg_dst,
    output logic                   o_alu_src,
    output logic                   o_branch,
    output logic                   o_jump,
    output logic [NB_CNT-1:0]      o_stall_cnt
);

    localparam int NREG = 1 << NB_REG_ADDR;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem2reg;
        logic reg_dst;
        logic alu_src;
        logic branch;
        logic jump;
    } ctrl_t;

    // ---------------- instruction fields ----------------
    logic [5:0]             dec_opcode;
    logic [5:0]             dec_func;
    logic [4:0]             dec_shamt;
    logic [NB_REG_ADDR-1:0] dec_rs;
    logic [NB_REG_ADDR-1:0] dec_rt;
    logic [NB_REG_ADDR-1:0] dec_rd;
    logic [25:0]            dec_jaddr;
    logic [15:0]            imm16;
    logic signed [15:0]     imm16_s;

    assign dec_opcode = i_instruction[31:26];
    assign dec_rs     = NB_REG_ADDR'(i_instruction[25:21]);
    assign dec_rt     = NB_REG_ADDR'(i_instruction[20:16]);
    assign dec_rd     = NB_REG_ADDR'(i_instruction[15:11]);
    assign dec_shamt  = i_instruction[10:6];
    assign dec_func   = i_instruction[5:0];
    assign dec_jaddr  = i_instruction[25:0];
    assign imm16      = i_instruction[15:0];
    assign imm16_s    = i_instruction[15:0];

    // ---------------- register file ----------------
    logic [NB_DATA-1:0] rf_q [NREG];
    logic               wb_en;
    logic [NB_DATA-1:0] rd_data_a;
    logic [NB_DATA-1:0] rd_data_b;

    assign wb_en = i_wb_we && (i_wb_addr != '0);

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_en) begin
            rf_q[i_wb_addr] <= i_wb_data;
        end
    end

    // Write-through lets a writeback in this cycle feed the instruction being decoded.
    assign rd_data_a = (dec_rs == '0) ? '0 :
                       (wb_en && (i_wb_addr == dec_rs)) ? i_wb_data : rf_q[dec_rs];
    assign rd_data_b = (dec_rt == '0) ? '0 :
                       (wb_en && (i_wb_addr == dec_rt)) ? i_wb_data : rf_q[dec_rt];

    // ---------------- immediate and control decode ----------------
    logic [NB_DATA-1:0] dec_imm;
    ctrl_t              dec_ctrl;

    always_comb begin
        case (dec_opcode)
            OP_ANDI, OP_ORI, OP_XORI: dec_imm = NB_DATA'(imm16);
            OP_LUI:                   dec_imm = NB_DATA'({imm16, 16'h0000});
            default:                  dec_imm = NB_DATA'(imm16_s);
        endcase
    end

    always_comb begin
        dec_ctrl = '0;
        case (dec_opcode)
            OP_RTYPE: begin
                dec_ctrl.reg_dst   = 1'b1;
                dec_ctrl.reg_write = (dec_func != FN_JR);
                dec_ctrl.jump      = (dec_func == FN_JR);
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_SLTI: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
            end
            OP_LW: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.mem_read  = 1'b1;
                dec_ctrl.mem2reg   = 1'b1;
            end
            OP_SW: begin
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.mem_write = 1'b1;
            end
            OP_BEQ, OP_BNE: dec_ctrl.branch = 1'b1;
            OP_J:           dec_ctrl.jump   = 1'b1;
            OP_JAL: begin
                dec_ctrl.jump      = 1'b1;
                dec_ctrl.reg_write = 1'b1;
            end
            default: dec_ctrl = '0;
        endcase
    end

    // ---------------- hazard and handshake ----------------
    logic hazard;

    assign hazard  = i_valid && i_ex_mem_read && (i_ex_rt != '0) &&
                     ((i_ex_rt == dec_rs) || (i_ex_rt == dec_rt));
    assign o_ready = i_flush || (i_ready && !hazard);

    // ---------------- output register next state ----------------
    logic                   valid_q,  valid_d;
    logic [5:0]             opcode_q, opcode_d;
    logic [5:0]             func_q,   func_d;
    logic [4:0]             shamt_q,  shamt_d;
    logic [NB_REG_ADDR-1:0] rs_q,     rs_d;
    logic [NB_REG_ADDR-1:0] rt_q,     rt_d;
    logic [NB_REG_ADDR-1:0] rd_q,     rd_d;
    logic [NB_DATA-1:0]     data_a_q, data_a_d;
    logic [NB_DATA-1:0]     data_b_q, data_b_d;
    logic [NB_DATA-1:0]     imm_q,    imm_d;
    logic [25:0]            jaddr_q,  jaddr_d;
    logic [NB_DATA-1:0]     pc4_q,    pc4_d;
    ctrl_t                  ctrl_q,   ctrl_d;
    logic [NB_CNT-1:0]      stall_cnt_q, stall_cnt_d;
    logic                   take_bubble;
    logic                   take_load;

    // Flush beats hold; a hazard only bubbles when EX is able to take the bubble.
    always_comb begin
        take_bubble = 1'b0;
        take_load   = 1'b0;
        stall_cnt_d = stall_cnt_q;
        if (i_flush) begin
            take_bubble = 1'b1;
        end else if (i_ready) begin
            if (hazard) begin
                take_bubble = 1'b1;
                if (stall_cnt_q != '1) begin
                    stall_cnt_d = stall_cnt_q + 1'b1;
                end
            end else if (i_valid) begin
                take_load = 1'b1;
            end else begin
                take_bubble = 1'b1;
            end
        end
    end

    always_comb begin
        valid_d  = valid_q;
        opcode_d = opcode_q;
        func_d   = func_q;
        shamt_d  = shamt_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        rd_d     = rd_q;
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        imm_d    = imm_q;
        jaddr_d  = jaddr_q;
        pc4_d    = pc4_q;
        ctrl_d   = ctrl_q;
        if (take_bubble) begin
            valid_d  = 1'b0;
            opcode_d = '0;
            func_d   = '0;
            shamt_d  = '0;
            rs_d     = '0;
            rt_d     = '0;
            rd_d     = '0;
            data_a_d = '0;
            data_b_d = '0;
            imm_d    = '0;
            jaddr_d  = '0;
            pc4_d    = '0;
            ctrl_d   = '0;
        end else if (take_load) begin
            valid_d  = 1'b1;
            opcode_d = dec_opcode;
            func_d   = dec_func;
            shamt_d  = dec_shamt;
            rs_d     = dec_rs;
            rt_d     = dec_rt;
            rd_d     = dec_rd;
            data_a_d = rd_data_a;
            data_b_d = rd_data_b;
            imm_d    = dec_imm;
            jaddr_d  = dec_jaddr;
            pc4_d    = i_pc4;
            ctrl_d   = dec_ctrl;
        end
    end

    // ---------------- output register ----------------
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q     <= 1'b0;
            opcode_q    <= '0;
            func_q      <= '0;
            shamt_q     <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            data_a_q    <= '0;
            data_b_q    <= '0;
            imm_q       <= '0;
            jaddr_q     <= '0;
            pc4_q       <= '0;
            ctrl_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            opcode_q    <= opcode_d;
            func_q      <= func_d;
            shamt_q     <= shamt_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
            data_a_q    <= data_a_d;
            data_b_q    <= data_b_d;
            imm_q       <= imm_d;
            jaddr_q     <= jaddr_d;
            pc4_q       <= pc4_d;
            ctrl_q      <= ctrl_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_valid     = valid_q;
    assign o_opcode    = opcode_q;
    assign o_func      = func_q;
    assign o_shamt     = shamt_q;
    assign o_rs        = rs_q;
    assign o_rt        = rt_q;
    assign o_rd        = rd_q;
    assign o_data_a    = data_a_q;
    assign o_data_b    = data_b_q;
    assign o_imm       = imm_q;
    assign o_jaddr     = jaddr_q;
    assign o_pc4       = pc4_q;
    assign o_reg_write = ctrl_q.reg_write;
    assign o_mem_read  = ctrl_q.mem_read;
    assign o_mem_write = ctrl_q.mem_write;
    assign o_mem2reg   = ctrl_q.mem2reg;
    assign o_reg_dst   = ctrl_q.reg_dst;
    assign o_alu_src   = ctrl_q.alu_src;
    assign o_branch    = ctrl_q.branch;
    assign o_jump      = ctrl_q.jump;
    assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: decode vector table plus hand sequences for
// write-through, load-use stall, hold/flush, stall saturation and async reset.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic [31:0] i_instruction = '0;
    logic [31:0] i_pc4 = '0;
    logic        o_ready;
    logic        i_ex_mem_read = 1'b0;
    logic [4:0]  i_ex_rt = '0;
    logic        i_flush = 1'b0;
    logic        i_ready = 1'b1;
    logic        i_wb_we = 1'b0;
    logic [4:0]  i_wb_addr = '0;
    logic [31:0] i_wb_data = '0;
    logic        o_valid;
    logic [5:0]  o_opcode, o_func;
    logic [4:0]  o_shamt, o_rs, o_rt, o_rd;
    logic [31:0] o_data_a, o_data_b, o_imm, o_pc4;
    logic [25:0] o_jaddr;
    logic        o_reg_write, o_mem_read, o_mem_write, o_mem2reg;
    logic        o_reg_dst, o_alu_src, o_branch, o_jump;
    logic [7:0]  o_stall_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_stage_pipe #(.NB_DATA(32), .NB_REG_ADDR(5), .NB_CNT(8)) dut (
        .clk(clk), .i_rst(i_rst),
        .i_valid(i_valid), .i_instruction(i_instruction), .i_pc4(i_pc4), .o_ready(o_ready),
        .i_ex_mem_read(i_ex_mem_read), .i_ex_rt(i_ex_rt), .i_flush(i_flush), .i_ready(i_ready),
        .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
        .o_valid(o_valid), .o_opcode(o_opcode), .o_func(o_func), .o_shamt(o_shamt),
        .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_data_a(o_data_a), .o_data_b(o_data_b),
        .o_imm(o_imm), .o_jaddr(o_jaddr), .o_pc4(o_pc4),
        .o_reg_write(o_reg_write), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
        .o_mem2reg(o_mem2reg), .o_reg_dst(o_reg_dst), .o_alu_src(o_alu_src),
        .o_branch(o_branch), .o_jump(o_jump), .o_stall_cnt(o_stall_cnt)
    );

    typedef struct {
        logic        vld;
        logic [31:0] ins;
        logic        exmr;
        logic [4:0]  exrt;
        logic        fl;
        logic        e_ready;
        logic        e_vld;
        logic [7:0]  e_ctrl;
        logic [31:0] e_imm;
        logic [31:0] e_da;
        logic [31:0] e_db;
        logic [7:0]  e_stall;
    } vec_t;

    vec_t tbl[21];

    function automatic logic [7:0] ctrl_now();
        return {o_reg_write, o_mem_read, o_mem_write, o_mem2reg,
                o_reg_dst, o_alu_src, o_branch, o_jump};
    endfunction

    function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic vec_t mkv(input logic vld, input logic [31:0] ins, input logic exmr,
                                 input logic [4:0] exrt, input logic fl, input logic e_ready,
                                 input logic e_vld, input logic [7:0] e_ctrl,
                                 input logic [31:0] e_imm, input logic [31:0] e_da,
                                 input logic [31:0] e_db, input logic [7:0] e_stall);
        vec_t v;
        v.vld = vld; v.ins = ins; v.exmr = exmr; v.exrt = exrt; v.fl = fl;
        v.e_ready = e_ready; v.e_vld = e_vld; v.e_ctrl = e_ctrl; v.e_imm = e_imm;
        v.e_da = e_da; v.e_db = e_db; v.e_stall = e_stall;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic exmr,
                         input logic [4:0] exrt, input logic fl, input logic rdy);
        i_valid = v; i_instruction = ins; i_ex_mem_read = exmr;
        i_ex_rt = exrt; i_flush = fl; i_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] exp_fields;
        logic [31:0] held_a;

        // Field order {op, rw mr mw m2r rdst asrc br j} : R=88 I-alu=84 lw=D4 sw=24 br=02 j=01 jal=81
        tbl[0]  = mkv(1, mk_r(1, 2, 3, 0, 6'h20),        0, 0, 0, 1, 1, 8'h88, 32'h00001820, 32'h1001, 32'h1002, 0);
        tbl[1]  = mkv(1, mk_i(6'h08, 4, 5, 16'hFFF0),    0, 0, 0, 1, 1, 8'h84, 32'hFFFFFFF0, 32'h1004, 32'h1005, 0);
        tbl[2]  = mkv(1, mk_i(6'h0D, 0, 6, 16'hFFF0),    0, 0, 0, 1, 1, 8'h84, 32'h0000FFF0, 32'h0,    32'h1006, 0);
        tbl[3]  = mkv(1, mk_i(6'h0F, 0, 7, 16'h1234),    0, 0, 0, 1, 1, 8'h84, 32'h12340000, 32'h0,    32'h1007, 0);
        tbl[4]  = mkv(1, mk_i(6'h0C, 9, 10, 16'h8000),   0, 0, 0, 1, 1, 8'h84, 32'h00008000, 32'h1009, 32'h100A, 0);
        tbl[5]  = mkv(1, mk_i(6'h0E, 11, 12, 16'h8001),  0, 0, 0, 1, 1, 8'h84, 32'h00008001, 32'h100B, 32'h100C, 0);
        tbl[6]  = mkv(1, mk_i(6'h0A, 1, 1, 16'h8000),    0, 0, 0, 1, 1, 8'h84, 32'hFFFF8000, 32'h1001, 32'h1001, 0);
        tbl[7]  = mkv(1, mk_i(6'h23, 6, 7, 16'h0004),    0, 0, 0, 1, 1, 8'hD4, 32'h00000004, 32'h1006, 32'h1007, 0);
        tbl[8]  = mkv(1, mk_i(6'h2B, 1, 2, 16'hFFFC),    0, 0, 0, 1, 1, 8'h24, 32'hFFFFFFFC, 32'h1001, 32'h1002, 0);
        tbl[9]  = mkv(1, mk_i(6'h04, 1, 2, 16'h0010),    0, 0, 0, 1, 1, 8'h02, 32'h00000010, 32'h1001, 32'h1002, 0);
        tbl[10] = mkv(1, mk_i(6'h05, 3, 4, 16'hFFFF),    0, 0, 0, 1, 1, 8'h02, 32'hFFFFFFFF, 32'h1003, 32'h1004, 0);
        tbl[11] = mkv(1, {6'h02, 26'h0123456},           0, 0, 0, 1, 1, 8'h01, 32'h00003456, 32'h0,    32'h1012, 0);
        tbl[12] = mkv(1, {6'h03, 26'h0000040},           0, 0, 0, 1, 1, 8'h81, 32'h00000040, 32'h0,    32'h0,    0);
        tbl[13] = mkv(1, mk_i(6'h3F, 2, 3, 16'hFFFE),    0, 0, 0, 1, 1, 8'h00, 32'hFFFFFFFE, 32'h1002, 32'h1003, 0);
        tbl[14] = mkv(0, mk_r(1, 2, 3, 0, 6'h20),        0, 0, 0, 1, 0, 8'h00, 32'h0,        32'h0,    32'h0,    0);
        tbl[15] = mkv(1, mk_r(3, 1, 4, 0, 6'h20),        1, 3, 0, 0, 0, 8'h00, 32'h0,        32'h0,    32'h0,    1);
        tbl[16] = mkv(1, mk_r(1, 2, 4, 0, 6'h20),        1, 2, 0, 0, 0, 8'h00, 32'h0,        32'h0,    32'h0,    2);
        tbl[17] = mkv(1, mk_r(0, 0, 5, 0, 6'h20),        1, 0, 0, 1, 1, 8'h88, 32'h00002820, 32'h0,    32'h0,    2);
        tbl[18] = mkv(1, mk_r(1, 2, 6, 0, 6'h20),        0, 1, 0, 1, 1, 8'h88, 32'h00003020, 32'h1001, 32'h1002, 2);
        tbl[19] = mkv(0, mk_r(1, 2, 6, 0, 6'h20),        1, 1, 0, 1, 0, 8'h00, 32'h0,        32'h0,    32'h0,    2);
        tbl[20] = mkv(1, mk_r(1, 2, 6, 0, 6'h20),        1, 1, 1, 1, 0, 8'h00, 32'h0,        32'h0,    32'h0,    2);

        // Reset with a valid instruction presented: everything must read zero.
        drive(1, mk_r(1, 2, 3, 0, 6'h20), 0, 0, 0, 1);
        i_pc4 = 32'h44;
        tick();
        tick();
        chk("rst_valid", o_valid, 0);
        chk("rst_stall", o_stall_cnt, 0);
        chk("rst_ctrl", ctrl_now(), 0);
        chk("rst_data", {o_data_a, o_imm}, 0);
        i_rst = 1'b0;

        // Preload r1..r31 = 0x1000 + index.
        drive(0, 32'h0, 0, 0, 0, 1);
        for (int r = 1; r < 32; r++) begin
            i_wb_we = 1'b1; i_wb_addr = 5'(r); i_wb_data = 32'h1000 + 32'(r);
            tick();
        end
        i_wb_we = 1'b0;

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].vld, tbl[i].ins, tbl[i].exmr, tbl[i].exrt, tbl[i].fl, 1'b1);
            i_pc4 = 32'h400 + 32'(4 * i);
            #1;
            chk($sformatf("v%0d_ready", i), o_ready, tbl[i].e_ready);
            tick();
            exp_fields = tbl[i].e_vld ? {6'h0, tbl[i].ins[31:26], tbl[i].ins[25:21], tbl[i].ins[20:16],
                                         tbl[i].ins[15:11], tbl[i].ins[10:6], tbl[i].ins[5:0],
                                         tbl[i].ins[25:0]} : 64'h0;
            chk($sformatf("v%0d_valid", i), o_valid, tbl[i].e_vld);
            chk($sformatf("v%0d_ctrl", i), ctrl_now(), tbl[i].e_ctrl);
            chk($sformatf("v%0d_imm", i), o_imm, tbl[i].e_imm);
            chk($sformatf("v%0d_data", i), {o_data_a, o_data_b}, {tbl[i].e_da, tbl[i].e_db});
            chk($sformatf("v%0d_fields", i), {6'h0, o_opcode, o_rs, o_rt, o_rd, o_shamt, o_func, o_jaddr},
                exp_fields);
            chk($sformatf("v%0d_pc4", i), o_pc4, tbl[i].e_vld ? 32'h400 + 32'(4 * i) : 32'h0);
            chk($sformatf("v%0d_stall", i), o_stall_cnt, tbl[i].e_stall);
        end

        // jr: jump without register write.
        drive(1, mk_r(31, 0, 0, 0, 6'h08), 0, 0, 0, 1);
        tick();
        chk("jr_jump", o_jump, 1);
        chk("jr_regwrite", o_reg_write, 0);

        // Writeback forwarded to same-cycle reads; r0 stays zero.
        i_wb_we = 1'b1; i_wb_addr = 5'd5; i_wb_data = 32'h1234;
        drive(1, mk_r(5, 5, 1, 0, 6'h20), 0, 0, 0, 1);
        tick();
        chk("wt_data_a", o_data_a, 32'h1234);
        chk("wt_data_b", o_data_b, 32'h1234);
        i_wb_addr = 5'd0; i_wb_data = 32'hFFFF;
        drive(1, mk_r(0, 5, 1, 0, 6'h20), 0, 0, 0, 1);
        tick();
        chk("r0_wt", o_data_a, 0);
        i_wb_we = 1'b0;
        tick();
        chk("r0_read", o_data_a, 0);
        chk("r5_read", o_data_b, 32'h1234);

        // Hold for three cycles, then flush during hold.
        drive(1, mk_r(1, 2, 3, 0, 6'h20), 0, 0, 0, 1);
        tick();
        held_a = o_data_a;
        chk("hold_load", held_a, 32'h1001);
        drive(1, mk_i(6'h23, 4, 5, 16'h0008), 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("hold%0d_ready", c), o_ready, 0);
            tick();
            chk($sformatf("hold%0d_out", c), {o_valid, o_opcode, ctrl_now(), o_data_a},
                {1'b1, 6'h00, 8'h88, held_a});
        end
        i_flush = 1'b1;
        #1;
        chk("flush_ready", o_ready, 1);
        tick();
        chk("flush_bubble", {o_valid, ctrl_now()}, 0);

        // Asynchronous reset in the middle of a hold.
        drive(1, mk_r(1, 2, 3, 0, 6'h20), 0, 0, 0, 1);
        tick();
        drive(1, mk_r(1, 2, 3, 0, 6'h20), 0, 0, 0, 0);
        tick();
        #2;
        i_rst = 1'b1;
        #1;
        chk("arst_valid", o_valid, 0);
        chk("arst_data", {o_data_a, o_pc4}, 0);
        chk("arst_ctrl_stall", {ctrl_now(), o_stall_cnt}, 0);
        #1;
        i_rst = 1'b0;
        drive(1, mk_i(6'h08, 1, 2, 16'h0005), 0, 0, 0, 1);
        tick();
        chk("post_rst_valid", o_valid, 1);
        chk("post_rst_imm", o_imm, 32'h5);
        chk("post_rst_rf", o_data_a, 0);

        // Load-use stall, then the add proceeds.
        drive(1, mk_r(8, 9, 10, 0, 6'h20), 1, 8, 0, 1);
        #1;
        chk("lu_ready", o_ready, 0);
        tick();
        chk("lu_bubble", o_valid, 0);
        chk("lu_stall", o_stall_cnt, 1);
        i_ex_mem_read = 1'b0;
        #1;
        chk("lu_ready2", o_ready, 1);
        tick();
        chk("lu_add", {o_valid, o_opcode, o_rs}, {1'b1, 6'h00, 5'd8});

        // Saturation of the stall counter.
        i_ex_mem_read = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            tick();
            if (k == 253) chk("stall_253", o_stall_cnt, 254);
        end
        chk("stall_sat", o_stall_cnt, 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
